// File: rtl/read_master.sv
// Avalon-MM pipelined word read master feeding a show-ahead FIFO; first read one cycle after go, data visible one cycle after readdatavalid.
// Backpressure: reads stall on waitrequest and whenever FIFO occupancy plus outstanding reads would exceed FIFODEPTH.
module read_master #(
  parameter int DATAWIDTH       = 32,
  parameter int BYTEENABLEWIDTH = 4,
  parameter int ADDRESSWIDTH    = 32,
  parameter int FIFODEPTH       = 32,
  parameter int FIFODEPTH_LOG2  = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       control_fixed_location,
  input  logic [ADDRESSWIDTH-1:0]    control_read_base,
  input  logic [ADDRESSWIDTH-1:0]    control_read_length,
  input  logic                       control_go,
  output logic                       control_early_done,
  output logic                       control_done,
  input  logic                       user_read_buffer,
  output logic [DATAWIDTH-1:0]       user_buffer_data,
  output logic                       user_data_available,
  output logic [ADDRESSWIDTH-1:0]    master_address,
  output logic                       master_read,
  output logic [BYTEENABLEWIDTH-1:0] master_byteenable,
  input  logic [DATAWIDTH-1:0]       master_readdata,
  input  logic                       master_readdatavalid,
  input  logic                       master_waitrequest
);

  localparam int CW = FIFODEPTH_LOG2 + 1;
  localparam logic [CW-1:0]             L_DEPTH    = CW'(FIFODEPTH);
  localparam logic [CW-1:0]             L_CNT_ONE  = CW'(1);
  localparam logic [FIFODEPTH_LOG2-1:0] L_PTR_ONE  = FIFODEPTH_LOG2'(1);
  localparam logic [ADDRESSWIDTH-1:0]   L_ADDR_ONE = ADDRESSWIDTH'(1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  state_t                    r_state;
  logic [ADDRESSWIDTH-1:0]   r_address;
  logic [ADDRESSWIDTH-1:0]   r_length;
  logic                      r_fixed_d1;
  logic [CW-1:0]             r_pending;
  logic [CW-1:0]             r_count;
  logic [FIFODEPTH_LOG2-1:0] r_wr_ptr;
  logic [FIFODEPTH_LOG2-1:0] r_rd_ptr;
  logic [DATAWIDTH-1:0]      r_mem [FIFODEPTH];

  logic          w_done;
  logic          w_go;
  logic [CW-1:0] w_occupancy;
  logic          w_accept;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_pending_nxt;

  assign w_done      = (r_length == '0) && (r_pending == '0);
  assign w_go        = control_go && w_done;
  // Every outstanding read already owns a FIFO slot, so returned data can never overflow.
  assign w_occupancy = r_count + r_pending;
  assign master_read = (r_state == S_ISSUE) && (w_occupancy < L_DEPTH);
  assign w_accept    = master_read && !master_waitrequest;
  // Data with nothing outstanding (e.g. a late return after reset) is dropped.
  assign w_push      = master_readdatavalid && (r_pending != '0);
  assign w_pop       = user_read_buffer && (r_count != '0);

  always_comb begin
    w_pending_nxt = r_pending;
    case ({w_accept, w_push})
      2'b10:   w_pending_nxt = r_pending + L_CNT_ONE;
      2'b01:   w_pending_nxt = r_pending - L_CNT_ONE;
      default: w_pending_nxt = r_pending;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_address  <= '0;
      r_length   <= '0;
      r_fixed_d1 <= 1'b0;
      r_pending  <= '0;
    end else begin
      r_pending <= w_pending_nxt;
      if (w_go) begin
        r_address  <= control_read_base;
        r_length   <= control_read_length;
        r_fixed_d1 <= control_fixed_location;
        r_state    <= (control_read_length != '0) ? S_ISSUE : S_IDLE;
      end else begin
        if (w_accept) begin
          r_length <= r_length - L_ADDR_ONE;
          if (!r_fixed_d1) begin
            r_address <= r_address + L_ADDR_ONE;
          end
        end
        case (r_state)
          S_ISSUE: if (w_accept && (r_length == L_ADDR_ONE)) r_state <= S_DRAIN;
          S_DRAIN: if (w_pending_nxt == '0) r_state <= S_IDLE;
          default: r_state <= r_state;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + L_PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + L_PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + L_CNT_ONE;
        2'b01:   r_count <= r_count - L_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= master_readdata;
  end

  assign user_buffer_data    = r_mem[r_rd_ptr];
  assign user_data_available = (r_count != '0);
  assign master_address      = r_address;
  assign master_byteenable   = '1;
  assign control_early_done  = (r_length == '0);
  assign control_done        = w_done;

endmodule

// File: tb/tb_read_master.sv
// Randomized bench for read_master: an in-order Avalon slave with random latency and
// waitrequest, a queue-based reference of issued addresses and returned data, and a popping monitor.
module tb_read_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        control_fixed_location = 1'b0;
  logic [31:0] control_read_base = '0;
  logic [31:0] control_read_length = '0;
  logic        control_go = 1'b0;
  logic        control_early_done;
  logic        control_done;
  logic        user_read_buffer = 1'b0;
  logic [31:0] user_buffer_data;
  logic        user_data_available;
  logic [31:0] master_address;
  logic        master_read;
  logic [3:0]  master_byteenable;
  logic [31:0] master_readdata = '0;
  logic        master_readdatavalid = 1'b0;
  logic        master_waitrequest = 1'b0;

  read_master dut (
    .clk                    (clk),
    .reset                  (reset),
    .control_fixed_location (control_fixed_location),
    .control_read_base      (control_read_base),
    .control_read_length    (control_read_length),
    .control_go             (control_go),
    .control_early_done     (control_early_done),
    .control_done           (control_done),
    .user_read_buffer       (user_read_buffer),
    .user_buffer_data       (user_buffer_data),
    .user_data_available    (user_data_available),
    .master_address         (master_address),
    .master_read            (master_read),
    .master_byteenable      (master_byteenable),
    .master_readdata        (master_readdata),
    .master_readdatavalid   (master_readdatavalid),
    .master_waitrequest     (master_waitrequest)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  // Reference model: reads still to be issued, words owed to the user, reads in flight.
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  int          model_pending = 0;
  int          resp_t[$];
  logic [31:0] resp_d[$];

  int          wait_pct = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  int          pop_pct = 100;
  bit          pop_once = 0;
  int          stall_at = -1;
  int          stall_len = 0;
  int          stall_cnt = 0;
  logic [31:0] held_addr = '0;
  int          acc_in_xfer = 0;
  int          last_acc_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit model_done();
    return (exp_addr.size() == 0) && (model_pending == 0);
  endfunction

  // Slave and user-side monitor, all on the falling edge.
  always @(negedge clk) begin : bus
    bit wr;
    int t;
    wr = 1'b0;
    if (reset) begin
      exp_addr.delete();
      exp_data.delete();
      model_pending = 0;
      user_read_buffer = 1'b0;
    end else begin
      check("data_available", user_data_available, exp_data.size() != 0);
      if (user_data_available && (pop_once || int'($urandom_range(0, 99)) < pop_pct)) begin
        user_read_buffer = 1'b1;
        pop_once = 0;
        if (exp_data.size() != 0) check("pop_data", user_buffer_data, exp_data.pop_front());
      end else begin
        user_read_buffer = 1'b0;
      end
    end

    if (resp_t.size() != 0 && resp_t[0] <= cyc) begin
      master_readdatavalid = 1'b1;
      master_readdata = resp_d.pop_front();
      void'(resp_t.pop_front());
      if (!reset && model_pending > 0) begin
        exp_data.push_back(master_readdata);
        model_pending--;
      end
    end else begin
      master_readdatavalid = 1'b0;
      master_readdata = $urandom;
    end

    if (!reset) begin
      if (acc_in_xfer == stall_at && stall_cnt <= stall_len && (master_read || stall_cnt > 0)) begin
        if (stall_cnt == 0) held_addr = master_address;
        else begin
          check("stall_read_held", master_read, 1);
          check("stall_addr_held", master_address, held_addr);
        end
        wr = (stall_cnt < stall_len);
        stall_cnt++;
      end else begin
        wr = int'($urandom_range(0, 99)) < wait_pct;
      end
    end
    master_waitrequest = wr;

    if (!reset && master_read && !wr) begin
      if (exp_addr.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_read: address=%0h accepted with no read left in the model", master_address);
      end else begin
        check("read_address", master_address, exp_addr.pop_front());
      end
      model_pending++;
      acc_in_xfer++;
      last_acc_cyc = cyc;
      t = cyc + int'($urandom_range(lat_max, lat_min));
      if (resp_t.size() != 0 && t <= resp_t[$]) t = resp_t[$] + 1;
      resp_t.push_back(t);
      resp_d.push_back($urandom);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [31:0] base, input logic [31:0] len, input bit fixed);
    control_read_base = base;
    control_read_length = len;
    control_fixed_location = fixed;
    control_go = 1'b1;
    if (model_done()) begin
      for (int i = 0; i < int'(len); i++) exp_addr.push_back(fixed ? base : base + 32'(i));
      acc_in_xfer = 0;
      stall_cnt = 0;
    end
    tick();
    control_go = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int done_cyc);
    done_cyc = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      check("early_done", control_early_done, exp_addr.size() == 0);
      check("done", control_done, model_done());
      if (control_done || model_done()) begin
        done_cyc = cyc;
        break;
      end
    end
    if (done_cyc < 0) begin
      checks++;
      errors++;
      $display("FAIL wait_done: not done after %0d cycles", budget);
    end
  endtask

  task automatic drain(input int budget);
    bit ok;
    ok = 0;
    pop_pct = 100;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (exp_data.size() == 0 && !user_data_available) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL drain: FIFO not empty after %0d cycles, model holds %0d", budget, exp_data.size());
    end
  endtask

  initial begin
    int dc;
    bit reached;

    repeat (3) tick();
    check("rst_done", control_done, 1);
    check("rst_early_done", control_early_done, 1);
    check("rst_read", master_read, 0);
    check("rst_available", user_data_available, 0);
    check("byteenable", master_byteenable, 4'hF);
    reset = 1'b0;
    tick();

    // Basic transfer, fixed latency 2, data popped afterwards.
    wait_pct = 0; lat_min = 2; lat_max = 2; pop_pct = 0;
    check("idle_no_read", master_read, 0);
    start(32'h100, 32'd4, 1'b0);
    check("first_read", master_read, 1);
    check("first_addr", master_address, 32'h100);
    wait_done(50, dc);
    check("done_delay", dc - last_acc_cyc, 3);
    drain(50);

    // Fixed address.
    lat_min = 1; lat_max = 3; pop_pct = 0;
    start(32'h40, 32'd3, 1'b1);
    wait_done(50, dc);
    tick();
    check("fixed_available", user_data_available, 1);
    drain(50);

    // Address wraps past the top of the space.
    lat_min = 1; lat_max = 4; pop_pct = 50; wait_pct = 20;
    start(32'hFFFF_FFFE, 32'd4, 1'b0);
    wait_done(100, dc);
    drain(50);

    // FIFO full with nothing popped: reads throttle to FIFO capacity.
    lat_min = 1; lat_max = 3; pop_pct = 0; wait_pct = 10;
    start(32'h1000, 32'd40, 1'b0);
    repeat (150) tick();
    check("full_reads", acc_in_xfer, 32);
    check("full_read_low", master_read, 0);
    pop_once = 1;
    repeat (30) tick();
    check("full_one_more", acc_in_xfer, 33);
    check("full_read_low2", master_read, 0);
    pop_pct = 100;
    wait_done(500, dc);
    drain(100);

    // Waitrequest held for 5 cycles on the second read.
    wait_pct = 0; lat_min = 1; lat_max = 2; stall_at = 1; stall_len = 5;
    start(32'h300, 32'd4, 1'b0);
    wait_done(100, dc);
    check("stall_cycles", stall_cnt, 6);
    check("stall_reads", acc_in_xfer, 4);
    stall_at = -1;
    drain(50);

    // go while busy is ignored.
    lat_min = 3; lat_max = 3;
    start(32'h200, 32'd10, 1'b0);
    repeat (2) tick();
    start(32'h900, 32'd5, 1'b0);
    wait_done(200, dc);
    check("busy_go_reads", acc_in_xfer, 10);
    drain(50);

    // Zero-length go issues nothing.
    start(32'h700, 32'd0, 1'b0);
    check("len0_read", master_read, 0);
    check("len0_done", control_done, 1);
    check("len0_early", control_early_done, 1);
    tick();
    check("len0_read2", master_read, 0);

    // Randomized transfers.
    for (int k = 0; k < 8; k++) begin
      wait_pct = int'($urandom_range(0, 40));
      lat_min = int'($urandom_range(1, 3));
      lat_max = lat_min + int'($urandom_range(0, 4));
      pop_pct = int'($urandom_range(20, 100));
      start($urandom, 32'($urandom_range(1, 48)), 1'($urandom_range(0, 1)));
      wait_done(3000, dc);
      drain(200);
    end

    // Reset with three reads outstanding; late data must be dropped.
    wait_pct = 0; lat_min = 8; lat_max = 8; pop_pct = 0;
    start(32'h500, 32'd3, 1'b0);
    reached = 0;
    for (int i = 0; i < 20; i++) begin
      if (model_pending == 3) begin
        reached = 1;
        break;
      end
      tick();
    end
    if (!reached) begin
      checks++;
      errors++;
      $display("FAIL reset_setup: three reads never outstanding");
    end
    reset = 1'b1;
    tick();
    check("midrst_done", control_done, 1);
    check("midrst_available", user_data_available, 0);
    check("midrst_read", master_read, 0);
    reset = 1'b0;
    repeat (20) tick();
    check("late_rdv_dropped", user_data_available, 0);
    check("late_rdv_done", control_done, 1);

    lat_min = 1; lat_max = 3; pop_pct = 100;
    start(32'h600, 32'd5, 1'b0);
    wait_done(100, dc);
    drain(50);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
